serial_add_sequencer: RTL and testbench

- Multi-cycle controller that adds or subtracts two WIDTH-bit operands bit-serially, LSB first.
- Uses one shared 1-bit full-adder slice: two HalfAdder instances plus an OR on the carries.
- Sequences operand shifting, carry storage and result assembly, with a start/busy/done/ack handshake.
- Serves as the area-minimal add/sub path of the 32-bit ALU, alongside the parallel adder.

---
 rtl/serial_add_sequencer.sv | 117 +++++++++++
 tb/tb_serial_add_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract controller: one shared full-adder slice, LSB first,
// with a start/busy/done/ack handshake. Area-minimal add/sub path of the ALU.
module serial_add_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cOut,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MSB_CIN  = CNT_W'(WIDTH - 2);

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-2:0] res;        // low WIDTH-1 result bits, filled from the top
  logic             carry_msb;  // carry into the MSB slice

  // Half adder: {carry, sum}
  function automatic logic [1:0] half_add(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

  logic [1:0] ha1;
  logic [1:0] ha2;
  logic       bit_s;
  logic       bit_c;

  // Shared full-adder slice built from two half adders and an OR on the carries
  assign ha1   = half_add(opa[0], opb[0]);
  assign ha2   = half_add(ha1[0], carry);
  assign bit_s = ha2[0];
  assign bit_c = ha1[1] | ha2[1];

  // Sequencer: latch operands, shift one bit per edge, present and hold the result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      opa       <= '0;
      opb       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      res       <= '0;
      carry_msb <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cOut      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= in1;
            opb   <= sub ? ~in2 : in2;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          res   <= (WIDTH-1)'({bit_s, res} >> 1);
          carry <= bit_c;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == MSB_CIN) begin
            carry_msb <= bit_c;
          end
          if (cnt == LAST_BIT) begin
            sum      <= {bit_s, res};
            cOut     <= bit_c;
            overflow <= carry_msb ^ bit_c;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          if (ack) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer (WIDTH=32).
module tb_serial_add_sequencer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             ack;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  serial_add_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sub      (sub),
    .in1      (in1),
    .in2      (in2),
    .ack      (ack),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cOut     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] esum;
    logic        ecout;
    logic        eovf;
  } vec_t;

  vec_t q[$];
  vec_t tbl[9];
  int   n_checks = 0;
  int   n_fails  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Issue one operation, wait for done, compare against the scoreboard, then handshake out.
  task automatic run_op(input vec_t v, input bit repulse, input int ack_wait,
                        input bit ack_early, input bit start_with_ack);
    int   n;
    int   busy_n;
    vec_t e;
    @(negedge clk);
    in1 = v.a; in2 = v.b; sub = v.s; start = 1'b1;
    if (ack_early) ack = 1'b1;
    q.push_back(v);
    @(negedge clk);
    start = 1'b0;
    in1 = $urandom; in2 = $urandom; sub = 1'($urandom_range(0, 1));
    n = 0; busy_n = 0;
    while (!done && n < 100) begin
      if (busy) busy_n++;
      if (repulse && n == 5) begin
        start = 1'b1; in1 = 32'd100; in2 = 32'd200; sub = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(32));
    chk("busy_cycles", 64'(busy_n), 64'(32));
    chk("busy_in_done", 64'(busy), 64'(0));
    if (q.size() == 0) begin
      chk("scoreboard_empty", 64'(0), 64'(1));
    end else begin
      e = q.pop_front();
      chk("sum", 64'(sum), 64'(e.esum));
      chk("cout", 64'(cout), 64'(e.ecout));
      chk("overflow", 64'(overflow), 64'(e.eovf));
    end
    if (ack_early) begin
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'(0));
      ack = 1'b0;
    end else begin
      for (int i = 0; i < ack_wait; i++) begin
        @(negedge clk);
        chk("done_hold", 64'(done), 64'(1));
        chk("sum_hold", 64'(sum), 64'(e.esum));
      end
      ack = 1'b1;
      if (start_with_ack) begin
        start = 1'b1; in1 = 32'd7; in2 = 32'd9; sub = 1'b0;
      end
      @(negedge clk);
      ack = 1'b0; start = 1'b0;
      chk("done_after_ack", 64'(done), 64'(0));
      chk("busy_after_ack", 64'(busy), 64'(0));
      if (start_with_ack) begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("no_restart", 64'(busy), 64'(0));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit   seen_done;

    tbl[0] = '{32'd5,          32'd3,          1'b0, 32'h0000_0008, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[2] = '{32'h7FFF_FFFF,  32'd1,          1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[3] = '{32'h8000_0000,  32'd1,          1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[4] = '{32'd5,          32'd3,          1'b1, 32'h0000_0002, 1'b1, 1'b0};
    tbl[5] = '{32'd3,          32'd5,          1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[6] = '{32'd0,          32'd0,          1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[7] = '{32'h1234_5678,  32'h1111_1111,  1'b0, 32'h2345_6789, 1'b0, 1'b0};
    tbl[8] = '{32'h8000_0000,  32'h8000_0000,  1'b0, 32'h0000_0000, 1'b1, 1'b1};

    reset = 1'b1; start = 1'b0; sub = 1'b0; ack = 1'b0; in1 = '0; in2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i], 1'b0, 0, 1'b0, 1'b0);
    end

    // start re-pulsed during RUN must not disturb the first operation
    run_op(tbl[0], 1'b1, 0, 1'b0, 1'b0);
    // ack withheld for 10 cycles
    run_op(tbl[5], 1'b0, 10, 1'b0, 1'b0);
    // start coinciding with ack in DONE is ignored
    run_op(tbl[4], 1'b0, 0, 1'b0, 1'b1);
    // ack held high from start: done for exactly one cycle
    run_op(tbl[7], 1'b0, 0, 1'b1, 1'b0);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    in1 = 32'h1234_5678; in2 = 32'h1111_1111; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_before_reset", 64'(busy), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_sum", 64'(sum), 64'(0));
    chk("arst_cout", 64'(cout), 64'(0));
    chk("arst_ovf", 64'(overflow), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    chk("no_done_after_reset", 64'(seen_done), 64'(0));

    v = '{32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0};
    run_op(v, 1'b0, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
